// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, constants and hex pattern table for seg_scan_driver
package seg_scan_pkg;

  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] AN_OFF    = 2'b11;

  // Active-low {g,f,e,d,c,b,a}; element [n] is the pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - selector-side and pin-side signals of the scan driver
interface seg_scan_driver_if;
  logic [7:0] SEG;
  logic [1:0] LED;
  logic [6:0] DIGIT_SEG;
  logic [1:0] DIGIT_AN;
  logic [1:0] LED_OUT;

  modport master (output SEG, LED, input DIGIT_SEG, DIGIT_AN, LED_OUT);
  modport slave  (input SEG, LED, output DIGIT_SEG, DIGIT_AN, LED_OUT);
endinterface

// File: rtl/seg_scan_driver_hex7seg.sv
// rtl/seg_scan_driver_hex7seg.sv - combinational 4-bit to active-low 7-segment decoder
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the active-low segment pattern
  always_comb begin
    seg = HEX_LUT[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - two-digit multiplexed 7-segment scanner; SEG_SCAN_BLANK_EN enables leading-zero blanking
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  seg_scan_driver_if.slave  bus
);

  localparam int CW = $clog2(max3(REFRESH_DIV, GAP_CYCLES, 2));
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  // A zero-length gap is only ever entered from reset, where it lasts one cycle.
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);
  localparam bit            NO_GAP    = (GAP_CYCLES == 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      frame_q, frame_d;
  logic [1:0]      led_out_q, led_out_d;
  logic [6:0]      digit_seg_q, digit_seg_d;
  logic [1:0]      digit_an_q, digit_an_d;
  logic [3:0]      nibble;
  logic [6:0]      hex_seg;
  logic            frame_start;

  // Sequence the scan states and time each one with the shared counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    unique case (state_q)
      SHOW0:   if (cnt_q == SHOW_LAST) state_d = NO_GAP ? SHOW1 : GAP0;
      GAP0:    if (cnt_q == GAP_LAST)  state_d = SHOW1;
      SHOW1:   if (cnt_q == SHOW_LAST) state_d = NO_GAP ? SHOW0 : GAP1;
      GAP1:    if (cnt_q == GAP_LAST)  state_d = SHOW0;
      default: state_d = GAP1;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Latch SEG and LED together only on entry into SHOW0 so digits and flags never tear
  always_comb begin
    frame_start = (state_d == SHOW0) && (state_q != SHOW0);
    frame_d     = frame_start ? bus.SEG : frame_q;
    led_out_d   = frame_start ? bus.LED : led_out_q;
  end

  // Decode the nibble belonging to the state being entered so outputs switch with the state
  always_comb begin
    nibble = (state_d == SHOW0) ? frame_d[3:0] : frame_d[7:4];
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // Compute next registered segment and anode drive from the next state
  always_comb begin
    digit_an_d  = AN_OFF;
    digit_seg_d = SEG_BLANK;
    unique case (state_d)
      SHOW0: begin
        digit_an_d  = 2'b10;
        digit_seg_d = hex_seg;
      end
      SHOW1: begin
        digit_an_d  = 2'b01;
        digit_seg_d = hex_seg;
`ifdef SEG_SCAN_BLANK_EN
        if (frame_d[7:4] == 4'h0) begin
          digit_an_d  = AN_OFF;
          digit_seg_d = SEG_BLANK;
        end
`endif
      end
      default: begin
        digit_an_d  = AN_OFF;
        digit_seg_d = SEG_BLANK;
      end
    endcase
  end

  // State, counter, frame latch and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= GAP1;
      cnt_q       <= '0;
      frame_q     <= 8'h00;
      led_out_q   <= 2'b11;
      digit_seg_q <= SEG_BLANK;
      digit_an_q  <= AN_OFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      led_out_q   <= led_out_d;
      digit_seg_q <= digit_seg_d;
      digit_an_q  <= digit_an_d;
    end
  end

  assign bus.DIGIT_SEG = digit_seg_q;
  assign bus.DIGIT_AN  = digit_an_q;
  assign bus.LED_OUT   = led_out_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver (REFRESH_DIV=4, GAP_CYCLES=1)
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  seg_scan_driver_if bus();

  seg_scan_driver #(.REFRESH_DIV(4), .GAP_CYCLES(1)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count edges since reset; frame is 10 cycles, phase 0 captures inputs
  int         k_m;
  logic [7:0] cap_seg;
  logic [1:0] cap_led;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_m     <= 0;
      cap_seg <= 8'h00;
      cap_led <= 2'b11;
    end else begin
      k_m <= k_m + 1;
      if (k_m % 10 == 0) begin
        cap_seg <= bus.SEG;
        cap_led <= bus.LED;
      end
    end
  end

  function automatic logic [6:0] ref_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [1:0] ea;
    logic [6:0] es;
    int p;
    ea = 2'b11;
    es = 7'h7F;
    if (k_m > 0) begin
      p = (k_m - 1) % 10;
      if (p < 4) begin
        ea = 2'b10;
        es = ref_hex(cap_seg[3:0]);
      end else if (p >= 5 && p <= 8) begin
        ea = 2'b01;
        es = ref_hex(cap_seg[7:4]);
`ifdef SEG_SCAN_BLANK_EN
        if (cap_seg[7:4] == 4'h0) begin
          ea = 2'b11;
          es = 7'h7F;
        end
`endif
      end
    end
    check({tag, ".an"},  {30'd0, bus.DIGIT_AN},  {30'd0, ea});
    check({tag, ".seg"}, {25'd0, bus.DIGIT_SEG}, {25'd0, es});
    check({tag, ".led"}, {30'd0, bus.LED_OUT},   {30'd0, cap_led});
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (k_m > 0 && (k_m - 1) % 10 == p) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_phase: phase %0d not reached within 25 cycles", p);
  endtask

  typedef struct {
    logic [7:0] seg;
    logic [1:0] led;
    logic [6:0] d0;
    logic [1:0] an1;
    logic [6:0] d1;
  } vec_t;

  vec_t vecs[6];
  logic [1:0] an_seq[10];
  logic [6:0] seg_seq[10];

  initial begin
    vecs[0] = '{8'hA5, 2'b10, 7'b0010010, 2'b01, 7'b0001000};
`ifdef SEG_SCAN_BLANK_EN
    vecs[1] = '{8'h07, 2'b01, 7'b1111000, 2'b11, 7'h7F};
`else
    vecs[1] = '{8'h07, 2'b01, 7'b1111000, 2'b01, 7'b1000000};
`endif
    vecs[2] = '{8'h11, 2'b00, 7'b1111001, 2'b01, 7'b1111001};
    vecs[3] = '{8'h88, 2'b11, 7'b0000000, 2'b01, 7'b0000000};
    vecs[4] = '{8'hF0, 2'b10, 7'b1000000, 2'b01, 7'b0001110};
    vecs[5] = '{8'h3C, 2'b01, 7'b1000110, 2'b01, 7'b0110000};
    // Expected scan with SEG=8'h21 held: digit0 shows 1, digit1 shows 2
    an_seq  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
    seg_seq = '{7'h79, 7'h79, 7'h79, 7'h79, 7'h7F, 7'h24, 7'h24, 7'h24, 7'h24, 7'h7F};

    bus.SEG = 8'h21;
    bus.LED = 2'b10;
    rst_n   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.an",  {30'd0, bus.DIGIT_AN},  32'h3);
    check("rst.seg", {25'd0, bus.DIGIT_SEG}, 32'h7F);
    check("rst.led", {30'd0, bus.LED_OUT},   32'h3);

    // Release: SHOW0 on first edge, then the 4/1/4/1 sequence, two frames
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("seq%0d.an", i),  {30'd0, bus.DIGIT_AN},  {30'd0, an_seq[i % 10]});
      check($sformatf("seq%0d.seg", i), {25'd0, bus.DIGIT_SEG}, {25'd0, seg_seq[i % 10]});
    end
    check("seq.led", {30'd0, bus.LED_OUT}, 32'h2);

    // Table vectors: load in GAP1, check both digits and LED of the next frame
    for (int v = 0; v < 6; v++) begin
      wait_phase(9);
      bus.SEG = vecs[v].seg;
      bus.LED = vecs[v].led;
      @(negedge clk);
      check($sformatf("vec%0d.an0", v),  {30'd0, bus.DIGIT_AN},  32'h2);
      check($sformatf("vec%0d.seg0", v), {25'd0, bus.DIGIT_SEG}, {25'd0, vecs[v].d0});
      check($sformatf("vec%0d.led", v),  {30'd0, bus.LED_OUT},   {30'd0, vecs[v].led});
      wait_phase(4);
      check($sformatf("vec%0d.gap", v),  {25'd0, bus.DIGIT_SEG}, 32'h7F);
      wait_phase(5);
      check($sformatf("vec%0d.an1", v),  {30'd0, bus.DIGIT_AN},  {30'd0, vecs[v].an1});
      check($sformatf("vec%0d.seg1", v), {25'd0, bus.DIGIT_SEG}, {25'd0, vecs[v].d1});
    end

    // Mid-frame change during SHOW1 is ignored until the next frame start
    wait_phase(9);
    bus.SEG = 8'h11;
    wait_phase(6);
    bus.SEG = 8'h88;
    @(negedge clk);
    check("mid.an1",  {30'd0, bus.DIGIT_AN},  32'h1);
    check("mid.seg1", {25'd0, bus.DIGIT_SEG}, 32'h79);
    wait_phase(0);
    check("mid.seg0", {25'd0, bus.DIGIT_SEG}, 32'h00);

    // LED applied in GAP0 only appears at the next SHOW0 entry
    wait_phase(9);
    bus.LED = 2'b11;
    wait_phase(4);
    bus.LED = 2'b01;
    @(negedge clk);
    check("led.hold0", {30'd0, bus.LED_OUT}, 32'h3);
    wait_phase(9);
    check("led.hold1", {30'd0, bus.LED_OUT}, 32'h3);
    @(negedge clk);
    check("led.new",   {30'd0, bus.LED_OUT}, 32'h1);

    // Async reset between edges in SHOW1
    bus.SEG = 8'h21;
    bus.LED = 2'b10;
    wait_phase(6);
    #2 rst_n = 1'b0;
    #1;
    check("arst.an",  {30'd0, bus.DIGIT_AN},  32'h3);
    check("arst.seg", {25'd0, bus.DIGIT_SEG}, 32'h7F);
    check("arst.led", {30'd0, bus.LED_OUT},   32'h3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("rec%0d.an", i),  {30'd0, bus.DIGIT_AN},  {30'd0, an_seq[i]});
      check($sformatf("rec%0d.seg", i), {25'd0, bus.DIGIT_SEG}, {25'd0, seg_seq[i]});
    end

    // Randomized inputs against the frame-level model
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check_model($sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) bus.SEG = 8'($urandom);
      if ($urandom_range(0, 5) == 0) bus.LED = 2'($urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
